// File: rtl/bp_pkg.sv
// Shared types for the branch predictor update path.
// Table geometry, scheduler states and the queued update record.
package bp_pkg;

   localparam int ENTRIES = 16;
   localparam int IDX_W   = 4;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

   typedef struct packed {
      logic [IDX_W-1:0] index;
      logic             set;
      logic [31:0]      target;
   } update_t;

endpackage

// File: rtl/bp_update_fifo.sv
// Small synchronous FIFO of predictor table updates.
// Synchronous clear discards everything queued.
module bp_update_fifo
   import bp_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          push,
   input  update_t       din,
   input  logic          pop,
   output update_t       dout,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   update_t       mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers and occupancy; clear wins over push/pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array, written on accepted push.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bp_update_scheduler.sv
// Arbitrates predictor updates from two pipes into one write port.
// Also sequences a full-table invalidate on flush request.
module bp_update_scheduler
   import bp_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int ENTRIES = bp_pkg::ENTRIES,
   parameter int IDX_W   = bp_pkg::IDX_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req0_valid,
   output logic                       req0_ready,
   input  logic [31:0]                req0_pc,
   input  logic                       req0_taken,
   input  logic [31:0]                req0_target,
   input  logic                       req1_valid,
   output logic                       req1_ready,
   input  logic [31:0]                req1_pc,
   input  logic                       req1_taken,
   input  logic [31:0]                req1_target,
   input  logic                       tbl_busy,
   input  logic                       flush_req,
   output logic                       flush_done,
   output logic                       wr_en,
   output logic [IDX_W-1:0]           wr_index,
   output logic                       wr_set,
   output logic [31:0]                wr_target,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] flush_cnt;
   logic             last_grant;
   logic             grant0;
   logic             grant1;
   logic             push;
   logic             pop;
   logic             fifo_clr;
   logic             cnt_clr;
   logic             cnt_inc;
   logic             full;
   logic             empty;
   update_t          push_data;
   update_t          head;
   logic             unused_pc;

   assign unused_pc = ^{req0_pc[31:IDX_W], req1_pc[31:IDX_W]};

   // Round-robin on ties: favour the pipe not granted last.
   assign grant0 = req0_valid && (!req1_valid || last_grant);
   assign grant1 = req1_valid && (!req0_valid || !last_grant);

   bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (fifo_clr),
      .push  (push),
      .din   (push_data),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // State, flush index and last-grant pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RUN;
         flush_cnt  <= '0;
         last_grant <= 1'b1;
      end else begin
         state <= state_nxt;
         if (cnt_clr)      flush_cnt <= '0;
         else if (cnt_inc) flush_cnt <= flush_cnt + IDX_W'(1);
         if (push) last_grant <= grant1;
      end
   end

   // Next state, handshakes and table write port.
   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      push       = 1'b0;
      pop        = 1'b0;
      fifo_clr   = 1'b0;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      flush_done = 1'b0;
      wr_en      = 1'b0;
      wr_index   = head.index;
      wr_set     = head.set;
      wr_target  = head.target;
      push_data.index  = grant1 ? req1_pc[IDX_W-1:0] : req0_pc[IDX_W-1:0];
      push_data.set    = grant1 ? req1_taken : req0_taken;
      push_data.target = grant1 ? (req1_taken ? req1_target : 32'd0)
                                : (req0_taken ? req0_target : 32'd0);
      unique case (state)
         RUN: begin
            if (flush_req) begin
               fifo_clr  = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = FLUSH;
            end else begin
               req0_ready = grant0 && !full;
               req1_ready = grant1 && !full;
               push       = req0_ready || req1_ready;
               wr_en      = !empty && !tbl_busy;
               pop        = wr_en;
            end
         end
         FLUSH: begin
            wr_en     = !tbl_busy;
            wr_index  = flush_cnt;
            wr_set    = 1'b0;
            wr_target = 32'd0;
            cnt_inc   = wr_en;
            if (wr_en && flush_cnt == IDX_W'(ENTRIES - 1))
               state_nxt = DONE;
         end
         DONE: begin
            flush_done = 1'b1;
            state_nxt  = RUN;
         end
         default: state_nxt = RUN;
      endcase
      if (rst) begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
         push       = 1'b0;
         pop        = 1'b0;
         wr_en      = 1'b0;
         flush_done = 1'b0;
      end
   end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for the predictor update scheduler.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_bp_update_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req0_taken;
   logic [31:0] req0_pc, req0_target;
   logic        req1_valid, req1_ready, req1_taken;
   logic [31:0] req1_pc, req1_target;
   logic        tbl_busy, flush_req, flush_done;
   logic        wr_en, wr_set;
   logic [3:0]  wr_index;
   logic [31:0] wr_target;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   bp_update_scheduler #(.DEPTH(4), .ENTRIES(16), .IDX_W(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_pc     (req0_pc),
      .req0_taken  (req0_taken),
      .req0_target (req0_target),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_pc     (req1_pc),
      .req1_taken  (req1_taken),
      .req1_target (req1_target),
      .tbl_busy    (tbl_busy),
      .flush_req   (flush_req),
      .flush_done  (flush_done),
      .wr_en       (wr_en),
      .wr_index    (wr_index),
      .wr_set      (wr_set),
      .wr_target   (wr_target),
      .count       (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle();
      req0_valid = 0; req0_pc = 0; req0_taken = 0; req0_target = 0;
      req1_valid = 0; req1_pc = 0; req1_taken = 0; req1_target = 0;
      tbl_busy = 0; flush_req = 0;
   endtask

   task automatic do_reset();
      cyc(); rst = 1; idle();
      cyc(); rst = 0;
   endtask

   initial begin
      rst = 1;
      idle();
      req0_valid = 1;
      req1_valid = 1;
      #1;
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_done", 32'(flush_done), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_rdy0", 32'(req0_ready), 0);
      chk("rst_rdy1", 32'(req1_ready), 0);
      cyc(); rst = 0; idle();

      // single taken update
      cyc();
      req0_valid = 1; req0_pc = 32'h1003; req0_taken = 1;
      req0_target = 32'h2000;
      #1;
      chk("t1_rdy0", 32'(req0_ready), 1);
      chk("t1_wr_en0", 32'(wr_en), 0);
      cyc(); idle(); #1;
      chk("t1_wr_en", 32'(wr_en), 1);
      chk("t1_idx", 32'(wr_index), 3);
      chk("t1_set", 32'(wr_set), 1);
      chk("t1_tgt", wr_target, 32'h2000);
      cyc(); #1;
      chk("t1_count", 32'(count), 0);
      chk("t1_wr_en2", 32'(wr_en), 0);

      // alternating grants with table busy
      do_reset();
      req0_valid = 1; req0_pc = 32'h10; req0_taken = 1; req0_target = 32'hA0;
      req1_valid = 1; req1_pc = 32'h21; req1_taken = 1; req1_target = 32'hB1;
      tbl_busy = 1;
      #1;
      chk("rr_c1_r0", 32'(req0_ready), 1);
      chk("rr_c1_r1", 32'(req1_ready), 0);
      cyc(); #1;
      chk("rr_c2_r0", 32'(req0_ready), 0);
      chk("rr_c2_r1", 32'(req1_ready), 1);
      cyc(); #1;
      chk("rr_c3_r0", 32'(req0_ready), 1);
      cyc(); #1;
      chk("rr_c4_r1", 32'(req1_ready), 1);
      cyc(); #1;
      chk("rr_c5_count", 32'(count), 4);
      chk("rr_c5_r0", 32'(req0_ready), 0);
      chk("rr_c5_r1", 32'(req1_ready), 0);

      // full FIFO: pop without push bypass
      cyc(); req1_valid = 0; tbl_busy = 0; #1;
      chk("full_wr_en", 32'(wr_en), 1);
      chk("full_idx", 32'(wr_index), 0);
      chk("full_tgt", wr_target, 32'hA0);
      chk("full_rdy0", 32'(req0_ready), 0);
      cyc(); tbl_busy = 1; #1;
      chk("full_count", 32'(count), 3);
      chk("full_rdy0b", 32'(req0_ready), 1);
      cyc(); idle(); #1;
      chk("drain_count", 32'(count), 4);
      chk("drain_idx1", 32'(wr_index), 1);
      chk("drain_tgt1", wr_target, 32'hB1);
      cyc(); #1;
      chk("drain_idx2", 32'(wr_index), 0);
      cyc(); #1;
      chk("drain_idx3", 32'(wr_index), 1);
      cyc(); #1;
      chk("drain_idx4", 32'(wr_index), 0);
      chk("drain_tgt4", wr_target, 32'hA0);
      cyc(); #1;
      chk("drain_empty", 32'(count), 0);
      chk("drain_wr_en", 32'(wr_en), 0);

      // not-taken update from pipe 1
      cyc();
      req1_valid = 1; req1_pc = 32'h7; req1_taken = 0;
      req1_target = 32'hDEADBEEF;
      #1;
      chk("nt_rdy1", 32'(req1_ready), 1);
      cyc(); idle(); #1;
      chk("nt_wr_en", 32'(wr_en), 1);
      chk("nt_idx", 32'(wr_index), 7);
      chk("nt_set", 32'(wr_set), 0);
      chk("nt_tgt", wr_target, 0);

      // flush discards queued updates
      cyc();
      tbl_busy = 1;
      req0_valid = 1; req0_pc = 32'h5; req0_taken = 1; req0_target = 32'h55;
      cyc(); cyc();
      cyc(); req0_valid = 0; tbl_busy = 0; flush_req = 1; #1;
      chk("fl_c0_count", 32'(count), 3);
      chk("fl_c0_wr_en", 32'(wr_en), 0);
      for (int i = 0; i < 16; i++) begin
         cyc(); flush_req = 0;
         req0_valid = 1; req0_pc = 32'h9; req0_target = 32'h99;
         #1;
         chk("fl_wr_en", 32'(wr_en), 1);
         chk("fl_idx", 32'(wr_index), 32'(i));
         chk("fl_set", 32'(wr_set), 0);
         chk("fl_rdy0", 32'(req0_ready), 0);
         chk("fl_count", 32'(count), 0);
      end
      cyc(); #1;
      chk("fl_done", 32'(flush_done), 1);
      chk("fl_done_wr", 32'(wr_en), 0);
      chk("fl_done_rdy", 32'(req0_ready), 0);
      cyc(); #1;
      chk("fl_after_done", 32'(flush_done), 0);
      chk("fl_after_rdy", 32'(req0_ready), 1);
      cyc(); idle(); #1;
      chk("fl_after_wr", 32'(wr_en), 1);
      chk("fl_after_idx", 32'(wr_index), 9);

      // flush with a two-cycle stall
      cyc(); flush_req = 1; #1;
      chk("st_c0_wr", 32'(wr_en), 0);
      for (int c = 1; c <= 18; c++) begin
         cyc();
         flush_req = (c <= 3);
         tbl_busy = (c == 5 || c == 6);
         #1;
         chk("st_wr_en", 32'(wr_en), 32'(!(c == 5 || c == 6)));
         if (!(c == 5 || c == 6))
            chk("st_idx", 32'(wr_index), 32'((c < 5) ? c - 1 : c - 3));
         chk("st_nodone", 32'(flush_done), 0);
      end
      cyc(); idle(); #1;
      chk("st_done19", 32'(flush_done), 1);
      cyc(); #1;
      chk("st_run20", 32'(flush_done), 0);

      // reset in the middle of a flush
      cyc(); flush_req = 1;
      for (int c = 1; c <= 6; c++) begin
         cyc(); flush_req = 0; #1;
         chk("rf_idx", 32'(wr_index), 32'(c - 1));
      end
      #1 rst = 1;
      #1;
      chk("rf_wr_en", 32'(wr_en), 0);
      chk("rf_count", 32'(count), 0);
      chk("rf_done", 32'(flush_done), 0);
      cyc(); rst = 0;
      req0_valid = 1; req0_pc = 32'hC; req0_taken = 1; req0_target = 32'hC0;
      #1;
      chk("rf_rdy0", 32'(req0_ready), 1);
      cyc(); idle(); #1;
      chk("rf_count1", 32'(count), 1);
      chk("rf_wr_en2", 32'(wr_en), 1);
      chk("rf_idx2", 32'(wr_index), 12);
      chk("rf_tgt2", wr_target, 32'hC0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bp_update_scheduler.md
# bp_update_scheduler

Sequences all writes into the 16-entry branch predictor table (target table plus valid/prediction bits). Arbitrates branch-resolution updates from two execute pipes, buffers them in a small FIFO, and drains one update per cycle into the table's single write port whenever the lookup side is not busy. Also runs a full-table invalidate sequence on request, e.g. after a context switch or self-modifying-code fence.

## Interface
- DEPTH, 4: update FIFO entries (power of two, ≥2)
- ENTRIES, 16: predictor table entries
- IDX_W, 4: table index width, log2(ENTRIES)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  resolved-branch update pending from pipe 0 / 1
- req0_ready / req1_ready  out  1  update accepted this cycle
- req0_pc / req1_pc  in  32  branch PC
- req0_taken / req1_taken  in  1  resolved direction
- req0_target / req1_target  in  32  resolved target
- tbl_busy  in  1  table port in use by lookup; no write this cycle
- flush_req  in  1  level; starts invalidate sequence when sampled in RUN
- flush_done  out  1  one-cycle pulse, sequence complete
- wr_en  out  1  table write strobe
- wr_index  out  IDX_W  table index
- wr_set  out  1  1: write target, set prediction bit; 0: clear prediction bit
- wr_target  out  32  target written when wr_set=1
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Index is pc[IDX_W-1:0]. Taken update → wr_set=1, wr_target=target. Not-taken → wr_set=0, wr_target=0.
- States: RUN, FLUSH, DONE. Reset → RUN.
- RUN accept: at most one request per cycle; accept only if FIFO not full and flush_req=0. No push bypass on full, even with a simultaneous pop.
- Arbitration: both valid → grant the requester not granted last. Single valid → grant it. The last-grant pointer updates only on an accepted request. Reset pointer = 1, so req0 wins the first tie.
- RUN drain: wr_en = FIFO non-empty && !tbl_busy; wr_* driven from FIFO head; pop on wr_en. Push and pop in the same cycle leave count unchanged.
- flush_req sampled high in RUN → FIFO cleared, pending updates discarded, flush counter = 0, go to FLUSH.
- FLUSH: readies 0. wr_en = !tbl_busy, wr_set=0, wr_index = counter. Counter increments on each write. Write of index ENTRIES-1 → DONE.
- DONE: flush_done=1, wr_en=0, readies 0; next cycle → RUN. flush_req is ignored in FLUSH and DONE. If it is still high in RUN, a new flush starts.
- Reset mid-flush: sequence aborted; the table is left partially cleared.

## Timing
- Reset values: wr_en=0, flush_done=0, count=0, readies 0 while rst high, state RUN.
- readyN is combinational from valid, full, state, and flush_req. wr_* is combinational from FIFO head/state.
- Latency: request accepted at edge N → wr_en earliest in cycle N+1 (empty FIFO, tbl_busy=0).
- Flush with tbl_busy=0 throughout: flush_req high in cycle 0 → writes index 0..15 in cycles 1..16, flush_done in cycle 17, ready possible in cycle 18. Each tbl_busy cycle adds one cycle of stall.

## Structure
- Package bp_pkg: IDX_W, ENTRIES, state enum {RUN, FLUSH, DONE}, update struct {index, set, target}.
- Sub-module bp_update_fifo: synchronous FIFO of update structs with push/pop/full/empty/count and a synchronous clear.

## Test plan
- Single req0 taken, pc=0x1003, target=0x2000, tbl_busy=0 → next cycle wr_en=1, wr_index=3, wr_set=1, wr_target=0x2000; count returns to 0.
- Both valid for 4 consecutive cycles after reset, tbl_busy=1 → grants go req0, req1, req0, req1; count=4; both readies 0 in cycle 5.
- FIFO full, tbl_busy drops while req0 valid → pop that cycle with req0_ready=0; accepted the following cycle.
- Not-taken req1 pc=0x7 → wr_en with wr_index=7, wr_set=0, wr_target=0.
- 3 updates queued, flush_req pulsed with tbl_busy=0 → queued updates never written; 16 clears for index 0..15; flush_done in cycle 17; tbl_busy held 2 cycles mid-flush → flush_done in cycle 19.
- rst asserted during FLUSH at index 5 → immediately wr_en=0 and count=0; after release, state RUN and req0 accepted.
